rename_retire_core: RTL and testbench
=====================================

Name: rename_retire_core

Overview:
- Small RV32I-subset core with explicit register renaming: fetch/decode/rename, execute, then in-order retire through a reorder buffer (ROB).
- Keeps a speculative front RAT, a committed back RAT, a physical register file (PRF) and a free list.
- Top-level CPU block of the design. Exposes architectural/physical state on a debug bus and raises done when a halt instruction retires.

Parameters:
- ADDR_WIDTH, 32, PC / instruction address width.
- DATA_WIDTH, 32, register and datapath width.
- ARCH_REGS, 32, architectural registers.
- PHY_REGS, 64, physical registers (must be > ARCH_REGS).
- PHY_WIDTH, 6, log2(PHY_REGS).
- NUM_ROB_ENTRY, 16, ROB depth.
- ROB_WIDTH, 4, log2(NUM_ROB_ENTRY).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- boot_pc, input, ADDR_WIDTH: PC loaded while rst is high.
- imem_addr, output, ADDR_WIDTH: fetch address (equals pc).
- imem_data, input, 32: instruction at imem_addr; combinational, same-cycle.
- done, output, 1: sticky halt-retired flag.
- debug_info, output, Debug_t, with fields:
  - front_rat_out: ARCH_REGS*PHY_WIDTH.
  - back_rat_out: ARCH_REGS*PHY_WIDTH.
  - PRF_data_out: PHY_REGS*DATA_WIDTH.
  - retire_valid_reg: 1.
  - retire_addr_reg: ADDR_WIDTH.
  - Entry i sits at bits [i*W +: W].

Behaviour:
- Supported ISA:
  - ADDI, LUI, ADD, SUB.
  - EBREAK (0x00100073) = halt.
  - Any other encoding is a NOP: allocates a ROB entry with no destination.
- Reset state:
  - pc = boot_pc.
  - front and back RAT identity (arch i -> phys i).
  - PRF all zero.
  - Free list holds phys ARCH_REGS..PHY_REGS-1 in ascending order.
  - ROB empty; pipeline register invalid.
  - done = 0, retire_valid_reg = 0, retire_addr_reg = 0.
- Rename stage (cycle t):
  - Decode imem_data.
  - Read front RAT for rs1/rs2 before this cycle's update.
  - If rd != 0 and the instruction writes: pop a free preg, record old mapping, update front RAT[rd] at the edge.
  - Push ROB entry {pc, rd, new_preg, old_preg, has_dest, halt, complete=0}.
  - Latch operation into the execute register; pc += 4.
- Rename stall (no fetch, pc holds, nothing pushed) when any of:
  - ROB full.
  - Writing instruction and free list empty.
  - Halt already renamed.
- Writes to x0: never renamed, no preg consumed, x0 always reads phys 0 = 0.
- Execute stage (cycle t+1):
  - Read PRF sources; compute result (32-bit wrap).
  - At the edge write PRF[new_preg] and set the ROB entry's complete bit.
  - No bypass needed: a producer's PRF write lands before a back-to-back consumer executes.
- Retire (at most one per cycle, head only, when complete):
  - If has_dest: back RAT[rd] = new_preg and old_preg pushes to the free list.
  - Pop the ROB head.
  - retire_valid_reg <= 1 and retire_addr_reg <= pc, registered, one cycle per retirement; otherwise retire_valid_reg <= 0.
- Retiring a halt sets done at that edge; done stays high until rst.
- Simultaneous free-list pop (rename) and push (retire) in one cycle is legal. Same for ROB push and pop.
- Pointers wrap modulo depth. Full and empty are distinguished with an extra wrap bit.
- Minimum latency: rename t, execute t+1, retire edge end of t+2.
- rst asserted mid-run returns to the reset state immediately; in-flight work is discarded.

Optional Feature:
- RETIRE_TRACE_EN: when defined, every retirement prints in simulation "RETIRE pc=0x%08h rd=x%0d p%0d". When undefined there is no printing and the hardware is identical.

Decomposition:
- core_pkg holds:
  - parameter defaults.
  - Debug_t packed struct.
  - rob_entry_t struct.
  - opcode/funct constants.
  - EBREAK encoding.
- One sub-module, free_list: a circular FIFO of preg indices with push/pop/empty/full.

Test Plan:
- ADDI/dependency chain. Program at boot_pc=0: addi x1,x0,5; addi x2,x1,7; add x3,x1,x2; sub x4,x3,x1; ebreak.
  - Retires 0x0, 0x4, 0x8, 0xC, 0x10 in order.
  - x1=5, x2=12, x3=17, x4=12.
  - front_rat[1..4]=32..35; back_rat equals front_rat after done.
- LUI: lui x6,0x12345; ebreak -> x6=0x12345000, done=1.
- x0 write: addi x0,x0,9; ebreak -> x0 reads 0, front_rat[0]=0, free list count unchanged.
- Free-list recycling: 40 x addi x5,x5,1; ebreak -> x5=40 (more than 32 renames complete without deadlock); done=1.
- Unknown encoding 0xFFFFFFFF followed by ebreak -> retires as a NOP, no RAT change, done=1.
- Reset mid-run: assert rst after 3 cycles of the dependency-chain program -> RATs identity, PRF zero, done=0. The rerun then produces the same final results.

Source files
------------

// File: rtl/core_pkg.sv
// Shared parameters, debug bundle and ROB entry layout for rename_retire_core.
package core_pkg;
   localparam int ADDR_WIDTH    = 32;
   localparam int DATA_WIDTH    = 32;
   localparam int ARCH_REGS     = 32;
   localparam int AREG_WIDTH    = 5;
   localparam int PHY_REGS      = 64;
   localparam int PHY_WIDTH     = 6;
   localparam int NUM_ROB_ENTRY = 16;
   localparam int ROB_WIDTH     = 4;

   localparam logic [6:0]  OP_IMM = 7'b0010011;
   localparam logic [6:0]  OP_LUI = 7'b0110111;
   localparam logic [6:0]  OP_REG = 7'b0110011;
   localparam logic [2:0]  F3_ADD = 3'b000;
   localparam logic [6:0]  F7_ADD = 7'b0000000;
   localparam logic [6:0]  F7_SUB = 7'b0100000;
   localparam logic [31:0] EBREAK = 32'h00100073;

   typedef enum logic [2:0] {
      ALU_NOP, ALU_ADDI, ALU_LUI, ALU_ADD, ALU_SUB
   } alu_op_e;

   typedef struct packed {
      logic [ARCH_REGS*PHY_WIDTH-1:0] front_rat_out;
      logic [ARCH_REGS*PHY_WIDTH-1:0] back_rat_out;
      logic [PHY_REGS*DATA_WIDTH-1:0] PRF_data_out;
      logic                           retire_valid_reg;
      logic [ADDR_WIDTH-1:0]          retire_addr_reg;
   } Debug_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [AREG_WIDTH-1:0] rd;
      logic [PHY_WIDTH-1:0]  new_preg;
      logic [PHY_WIDTH-1:0]  old_preg;
      logic                  has_dest;
      logic                  halt;
      logic                  complete;
   } rob_entry_t;

   typedef struct packed {
      logic [ROB_WIDTH-1:0]  rob_idx;
      alu_op_e               op;
      logic [PHY_WIDTH-1:0]  ps1;
      logic [PHY_WIDTH-1:0]  ps2;
      logic [PHY_WIDTH-1:0]  pd;
      logic                  has_dest;
      logic [DATA_WIDTH-1:0] imm;
   } ex_t;
endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical register indices; resets holding the
// non-architectural pregs in ascending order.
module free_list
   import core_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push_i,
   input  logic [PHY_WIDTH-1:0] push_data_i,
   input  logic                 pop_i,
   output logic [PHY_WIDTH-1:0] pop_data_o,
   output logic                 empty_o,
   output logic                 full_o
);
   logic [PHY_WIDTH-1:0] mem_q [PHY_REGS];
   logic [PHY_WIDTH:0]   rd_q, wr_q;

   assign empty_o    = (rd_q == wr_q);
   assign full_o     = (rd_q[PHY_WIDTH] != wr_q[PHY_WIDTH]) &&
                       (rd_q[PHY_WIDTH-1:0] == wr_q[PHY_WIDTH-1:0]);
   assign pop_data_o = mem_q[rd_q[PHY_WIDTH-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PHY_REGS; i++)
            mem_q[i] <= PHY_WIDTH'(ARCH_REGS + i);
         rd_q <= '0;
         wr_q <= (PHY_WIDTH+1)'(PHY_REGS - ARCH_REGS);
      end else begin
         if (push_i && !full_o) begin
            mem_q[wr_q[PHY_WIDTH-1:0]] <= push_data_i;
            wr_q <= wr_q + 1'b1;
         end
         if (pop_i && !empty_o)
            rd_q <= rd_q + 1'b1;
      end
   end
endmodule

// File: rtl/rename_retire_core.sv
// RV32I-subset core: rename, execute, in-order retire through a ROB.
// Define RETIRE_TRACE_EN to print each retirement in simulation.
module rename_retire_core
   import core_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] boot_pc,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_data,
   output logic                  done,
   output Debug_t                debug_info
);
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [PHY_WIDTH-1:0]  front_rat_q [ARCH_REGS];
   logic [PHY_WIDTH-1:0]  back_rat_q  [ARCH_REGS];
   logic [DATA_WIDTH-1:0] prf_q [PHY_REGS];
   rob_entry_t            rob_q [NUM_ROB_ENTRY];
   logic [ROB_WIDTH:0]    head_q, tail_q;
   ex_t                   ex_q;
   logic                  ex_valid_q, halted_q, done_q;
   logic                  ret_valid_q;
   logic [ADDR_WIDTH-1:0] ret_addr_q;

   logic [6:0]            opc, f7;
   logic [2:0]            f3;
   logic [AREG_WIDTH-1:0] rd, rs1, rs2;
   alu_op_e               op;
   logic [DATA_WIDTH-1:0] imm, src_a, src_b, result;
   logic                  is_halt, has_dest, rob_full, rob_empty;
   logic                  fire, ret_fire;
   logic                  fl_empty, fl_full;
   logic [PHY_WIDTH-1:0]  fl_data;
   rob_entry_t            head;

   assign opc = imem_data[6:0];
   assign rd  = imem_data[11:7];
   assign f3  = imem_data[14:12];
   assign rs1 = imem_data[19:15];
   assign rs2 = imem_data[24:20];
   assign f7  = imem_data[31:25];

   always_comb begin
      op  = ALU_NOP;
      imm = '0;
      unique case (1'b1)
         (opc == OP_IMM && f3 == F3_ADD): begin
            op  = ALU_ADDI;
            imm = {{20{imem_data[31]}}, imem_data[31:20]};
         end
         (opc == OP_LUI): begin
            op  = ALU_LUI;
            imm = {imem_data[31:12], 12'b0};
         end
         (opc == OP_REG && f3 == F3_ADD && f7 == F7_ADD): op = ALU_ADD;
         (opc == OP_REG && f3 == F3_ADD && f7 == F7_SUB): op = ALU_SUB;
         default: ;
      endcase
   end

   assign is_halt   = (imem_data == EBREAK);
   assign has_dest  = (op != ALU_NOP) && (rd != '0);
   assign rob_empty = (head_q == tail_q);
   assign rob_full  = (head_q[ROB_WIDTH] != tail_q[ROB_WIDTH]) &&
                      (head_q[ROB_WIDTH-1:0] == tail_q[ROB_WIDTH-1:0]);
   assign fire      = !rob_full && !(has_dest && fl_empty) && !halted_q;
   assign head      = rob_q[head_q[ROB_WIDTH-1:0]];
   assign ret_fire  = !rob_empty && head.complete;

   free_list u_free_list (
      .clk         (clk),
      .rst         (rst),
      .push_i      (ret_fire && head.has_dest),
      .push_data_i (head.old_preg),
      .pop_i       (fire && has_dest),
      .pop_data_o  (fl_data),
      .empty_o     (fl_empty),
      .full_o      (fl_full)
   );

   always_comb begin
      src_a  = prf_q[ex_q.ps1];
      src_b  = prf_q[ex_q.ps2];
      result = '0;
      unique case (ex_q.op)
         ALU_ADDI: result = src_a + ex_q.imm;
         ALU_LUI:  result = ex_q.imm;
         ALU_ADD:  result = src_a + src_b;
         ALU_SUB:  result = src_a - src_b;
         default:  result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= boot_pc;
         for (int i = 0; i < ARCH_REGS; i++) begin
            front_rat_q[i] <= PHY_WIDTH'(i);
            back_rat_q[i]  <= PHY_WIDTH'(i);
         end
         for (int i = 0; i < PHY_REGS; i++)
            prf_q[i] <= '0;
         for (int i = 0; i < NUM_ROB_ENTRY; i++)
            rob_q[i] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         ex_q        <= '0;
         ex_valid_q  <= 1'b0;
         halted_q    <= 1'b0;
         done_q      <= 1'b0;
         ret_valid_q <= 1'b0;
         ret_addr_q  <= '0;
      end else begin
         ex_valid_q  <= fire;
         ret_valid_q <= ret_fire;
         if (fire) begin
            pc_q <= pc_q + 4;
            if (has_dest)
               front_rat_q[rd] <= fl_data;
            if (is_halt)
               halted_q <= 1'b1;
            rob_q[tail_q[ROB_WIDTH-1:0]] <= '{
               pc:       pc_q,
               rd:       rd,
               new_preg: has_dest ? fl_data : '0,
               old_preg: front_rat_q[rd],
               has_dest: has_dest,
               halt:     is_halt,
               complete: 1'b0
            };
            tail_q <= tail_q + 1'b1;
            ex_q   <= '{
               rob_idx:  tail_q[ROB_WIDTH-1:0],
               op:       op,
               ps1:      front_rat_q[rs1],
               ps2:      front_rat_q[rs2],
               pd:       fl_data,
               has_dest: has_dest,
               imm:      imm
            };
         end
         if (ex_valid_q) begin
            if (ex_q.has_dest)
               prf_q[ex_q.pd] <= result;
            rob_q[ex_q.rob_idx].complete <= 1'b1;
         end
         if (ret_fire) begin
            ret_addr_q <= head.pc;
            if (head.has_dest)
               back_rat_q[head.rd] <= head.new_preg;
            if (head.halt)
               done_q <= 1'b1;
            head_q <= head_q + 1'b1;
         end
      end
   end

`ifdef RETIRE_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst && ret_fire)
         $display("RETIRE pc=0x%08h rd=x%0d p%0d",
                  head.pc, head.rd, head.new_preg);
   end
`else
   // Trace disabled: no extra logic in this build.
`endif

   always_comb begin
      debug_info = '0;
      for (int i = 0; i < ARCH_REGS; i++) begin
         debug_info.front_rat_out[i*PHY_WIDTH +: PHY_WIDTH] = front_rat_q[i];
         debug_info.back_rat_out[i*PHY_WIDTH +: PHY_WIDTH]  = back_rat_q[i];
      end
      for (int i = 0; i < PHY_REGS; i++)
         debug_info.PRF_data_out[i*DATA_WIDTH +: DATA_WIDTH] = prf_q[i];
      debug_info.retire_valid_reg = ret_valid_q;
      debug_info.retire_addr_reg  = ret_addr_q;
   end

   assign imem_addr = pc_q;
   assign done      = done_q;
endmodule

// File: tb/tb_rename_retire_core.sv
// Scoreboard bench for rename_retire_core: directed programs plus random
// programs checked against an in-order architectural model.
module tb_rename_retire_core;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] boot_pc = '0;
   logic [31:0] imem_addr, imem_data;
   logic        done;
   Debug_t      debug_info;

   int          checks = 0;
   int          failures = 0;

   logic [31:0] mem [128];
   logic [31:0] regs [32];
   logic [31:0] exp_q [$];
   int          n;

   always #5 clk = ~clk;

   rename_retire_core dut (
      .clk        (clk),
      .rst        (rst),
      .boot_pc    (boot_pc),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .done       (done),
      .debug_info (debug_info)
   );

   always_comb begin
      logic [31:0] off;
      off = (imem_addr - boot_pc) >> 2;
      imem_data = (off < 128) ? mem[off[6:0]] : EBREAK;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", nm, act, exp);
      end
   endtask

   // Retirement monitor: pops the next expected pc for every retirement.
   always @(negedge clk) begin
      if (!rst && debug_info.retire_valid_reg) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL retire_extra got=0x%08h exp=none",
                     debug_info.retire_addr_reg);
         end else begin
            chk("retire_pc", debug_info.retire_addr_reg, exp_q.pop_front());
         end
      end
   end

   function automatic logic [5:0] front(input int r);
      return debug_info.front_rat_out[r*PHY_WIDTH +: PHY_WIDTH];
   endfunction

   function automatic logic [5:0] back(input int r);
      return debug_info.back_rat_out[r*PHY_WIDTH +: PHY_WIDTH];
   endfunction

   function automatic logic [31:0] arch_val(input int r);
      logic [5:0] p;
      p = back(r);
      return debug_info.PRF_data_out[int'(p)*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   task automatic begin_prog(input logic [31:0] bpc);
      rst = 1'b1;
      boot_pc = bpc;
      n = 0;
      for (int i = 0; i < 128; i++) mem[i] = EBREAK;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      exp_q.delete();
   endtask

   task automatic emit(input logic [31:0] w);
      mem[n] = w;
      exp_q.push_back(boot_pc + 32'(n) * 4);
      n++;
   endtask

   task automatic i_addi(input int rd, input int rs1, input logic [11:0] imm);
      emit({imm, 5'(rs1), 3'b000, 5'(rd), 7'h13});
      if (rd != 0) regs[rd] = regs[rs1] + {{20{imm[11]}}, imm};
   endtask

   task automatic i_lui(input int rd, input logic [19:0] imm);
      emit({imm, 5'(rd), 7'h37});
      if (rd != 0) regs[rd] = {imm, 12'b0};
   endtask

   task automatic i_add(input int rd, input int rs1, input int rs2);
      emit({7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33});
      if (rd != 0) regs[rd] = regs[rs1] + regs[rs2];
   endtask

   task automatic i_sub(input int rd, input int rs1, input int rs2);
      emit({7'h20, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33});
      if (rd != 0) regs[rd] = regs[rs1] - regs[rs2];
   endtask

   task automatic chain_prog();
      i_addi(1, 0, 12'd5);
      i_addi(2, 1, 12'd7);
      i_add(3, 1, 2);
      i_sub(4, 3, 1);
      emit(EBREAK);
   endtask

   task automatic chk_reset(input string nm);
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++)
         if (front(i) !== 6'(i) || back(i) !== 6'(i)) bad++;
      chk($sformatf("%s_rat_identity", nm), bad, 0);
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (debug_info.PRF_data_out[i*32 +: 32] !== 32'h0) bad++;
      chk($sformatf("%s_prf_zero", nm), bad, 0);
      chk($sformatf("%s_done", nm), done, 0);
      chk($sformatf("%s_ret_valid", nm), debug_info.retire_valid_reg, 0);
      chk($sformatf("%s_ret_addr", nm), debug_info.retire_addr_reg, 0);
   endtask

   task automatic run_prog(input string nm);
      int cyc;
      int bad;
      repeat (2) @(posedge clk);
      #1;
      chk_reset(nm);
      chk($sformatf("%s_boot_pc", nm), imem_addr, boot_pc);
      @(posedge clk);
      #1 rst = 1'b0;
      cyc = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("%s_done_seen", nm), done, 1);
      @(negedge clk);
      chk($sformatf("%s_drained", nm), exp_q.size(), 0);
      for (int r = 0; r < 32; r++)
         chk($sformatf("%s_x%0d", nm, r), arch_val(r), regs[r]);
      bad = 0;
      for (int r = 0; r < 32; r++)
         if (front(r) !== back(r)) bad++;
      chk($sformatf("%s_rat_sync", nm), bad, 0);
      repeat (4) @(negedge clk);
      chk($sformatf("%s_done_sticky", nm), done, 1);
   endtask

   initial begin
      logic [31:0] w;
      int len;
      int kind;

      begin_prog(32'h0);
      chain_prog();
      run_prog("chain");
      for (int r = 1; r <= 4; r++)
         chk($sformatf("chain_front_rat%0d", r), 32'(front(r)), 32'(31 + r));

      begin_prog(32'h100);
      i_lui(6, 20'h12345);
      emit(EBREAK);
      run_prog("lui");

      begin_prog(32'h40);
      i_addi(0, 0, 12'd9);
      i_addi(7, 0, 12'd1);
      emit(EBREAK);
      run_prog("x0");
      chk("x0_front_rat0", 32'(front(0)), 0);
      chk("x0_front_rat7", 32'(front(7)), 32);

      begin_prog(32'h0);
      for (int i = 0; i < 40; i++) i_addi(5, 5, 12'd1);
      emit(EBREAK);
      run_prog("recycle");
      chk("recycle_x5_40", arch_val(5), 32'd40);

      begin_prog(32'h200);
      emit(32'hFFFF_FFFF);
      emit(EBREAK);
      run_prog("unknown");
      for (int r = 0; r < 32; r++)
         chk($sformatf("unknown_rat%0d", r), 32'(front(r)), 32'(r));

      begin_prog(32'h0);
      chain_prog();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk_reset("midrst");
      begin_prog(32'h0);
      chain_prog();
      run_prog("rerun");

      for (int t = 0; t < 6; t++) begin
         begin_prog($urandom & 32'h0000_fffc);
         len = $urandom_range(10, 60);
         for (int k = 0; k < len; k++) begin
            kind = $urandom_range(0, 5);
            case (kind)
               0, 1: i_addi($urandom_range(0, 7), $urandom_range(0, 7),
                            12'($urandom));
               2: i_lui($urandom_range(0, 7), 20'($urandom));
               3: i_add($urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7));
               4: i_sub($urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7));
               default: begin
                  w = $urandom;
                  w[6:0] = 7'h7F;
                  emit(w);
               end
            endcase
         end
         emit(EBREAK);
         run_prog($sformatf("rand%0d", t));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
